clock_reset_seq: RTL and testbench

- Synthesizable, parametrised successor to the bench-only clock/reset generator.
- Runs on the single SoC clock. Produces CH_NUM staggered, sequenced reset outputs, one per sub-domain.
- Provides a programmable clock-enable divider per channel, with global enable gating and software-requested re-sequencing.
- Sits between the top-level clock/reset source and the CPU, bus and peripheral domains.

---
 rtl/clock_reset_seq.sv | 161 ++++++++++++++++
 tb/tb_clock_reset_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_reset_seq.sv
// clock_reset_seq
//   Sequenced reset release and per-channel clock-enable dividers for
//   CH_NUM sub-domains. Everything runs on one clock. Every output is a
//   flop, or a flop through an inverter.
//
//   State | meaning
//   ------+----------------------------------------------------------
//   S_ASSERT  | all resets held, counting one stage of hold_q+1 cycles
//   S_RELEASE | one channel released at the end of each stage, in index order
//   S_RUN     | all channels released; waits for soft_rst_req or reset
//
// Ports
//   clk           system clock (rising edge)
//   reset         synchronous active-high reset
//   ck_en         global gate for the dividers only
//   soft_rst_req  restart the reset sequence on the next edge
//   stage_hold    stage length minus 1 (captured on entry to S_ASSERT)
//   div_ratio     per-channel divide ratio, channel i at [i*DIV_W +: DIV_W]
//   ch_en         per-channel divider enable
//   rst_out       per-channel reset, active-high
//   ce_out        per-channel one-cycle clock-enable pulse
//   seq_done      all channels released
//   busy          ~seq_done
module clock_reset_seq #(
  parameter int CH_NUM = 4,
  parameter int HOLD_W = 16,
  parameter int DIV_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ck_en,
  input  logic                     soft_rst_req,
  input  logic [HOLD_W-1:0]        stage_hold,
  input  logic [CH_NUM*DIV_W-1:0]  div_ratio,
  input  logic [CH_NUM-1:0]        ch_en,
  output logic [CH_NUM-1:0]        rst_out,
  output logic [CH_NUM-1:0]        ce_out,
  output logic                     seq_done,
  output logic                     busy
);

  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_NUM - 1);

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  stage_cnt_q, stage_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CH_NUM-1:0]  rst_q, rst_d;
  logic               done_q, done_d;

  logic [DIV_W-1:0]   div_cnt_q [CH_NUM];
  logic [DIV_W-1:0]   div_cnt_d [CH_NUM];
  logic [CH_NUM-1:0]  ce_q, ce_d;

  // Sequencer next state. soft_rst_req overrides whatever the current
  // state would have done on this edge.
  always_comb begin
    state_d     = state_q;
    stage_cnt_d = stage_cnt_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    rst_d       = rst_q;
    done_d      = done_q;

    if (soft_rst_req) begin
      state_d     = S_ASSERT;
      stage_cnt_d = '0;
      hold_d      = stage_hold;
      idx_d       = '0;
      rst_d       = '1;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        S_ASSERT: begin
          rst_d = '1;
          if (stage_cnt_q == hold_q) begin
            stage_cnt_d = '0;
            idx_d       = '0;
            state_d     = S_RELEASE;
          end else begin
            stage_cnt_d = stage_cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (stage_cnt_q == hold_q) begin
            for (int i = 0; i < CH_NUM; i++) begin
              if (idx_q == IDX_W'(i)) rst_d[i] = 1'b0;
            end
            stage_cnt_d = '0;
            idx_d       = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              done_d  = 1'b1;
              state_d = S_RUN;
            end
          end else begin
            stage_cnt_d = stage_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
        end
        default: begin
          state_d = S_ASSERT;
        end
      endcase
    end
  end

  // Dividers. The >= compare makes a ratio lowered below the running
  // count fire on the next enabled edge instead of wrapping.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      div_cnt_d[i] = div_cnt_q[i];
      ce_d[i]      = 1'b0;
      if (soft_rst_req || rst_q[i] || !ch_en[i]) begin
        div_cnt_d[i] = '0;
      end else if (ck_en) begin
        if (div_cnt_q[i] >= div_ratio[i*DIV_W +: DIV_W]) begin
          ce_d[i]      = 1'b1;
          div_cnt_d[i] = '0;
        end else begin
          div_cnt_d[i] = div_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ASSERT;
      stage_cnt_q <= '0;
      hold_q      <= stage_hold;
      idx_q       <= '0;
      rst_q       <= '1;
      done_q      <= 1'b0;
      ce_q        <= '0;
      for (int i = 0; i < CH_NUM; i++) div_cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      stage_cnt_q <= stage_cnt_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      rst_q       <= rst_d;
      done_q      <= done_d;
      ce_q        <= ce_d;
      for (int i = 0; i < CH_NUM; i++) div_cnt_q[i] <= div_cnt_d[i];
    end
  end

  assign rst_out  = rst_q;
  assign ce_out   = ce_q;
  assign seq_done = done_q;
  assign busy     = ~done_q;

endmodule

// File: tb/tb_clock_reset_seq.sv
// tb_clock_reset_seq
//   Scoreboard bench for clock_reset_seq: expected edge numbers of reset
//   releases, seq_done rises and ce pulses are queued as each scenario is
//   set up, then popped and compared as the DUT produces those events.
module tb_clock_reset_seq;

  localparam int CH     = 4;
  localparam int HOLD_W = 16;
  localparam int DIV_W  = 8;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    ck_en;
  logic                    soft_rst_req;
  logic [HOLD_W-1:0]       stage_hold;
  logic [CH*DIV_W-1:0]     div_ratio;
  logic [CH-1:0]           ch_en;
  logic [CH-1:0]           rst_out;
  logic [CH-1:0]           ce_out;
  logic                    seq_done;
  logic                    busy;

  clock_reset_seq #(.CH_NUM(CH), .HOLD_W(HOLD_W), .DIV_W(DIV_W)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .ck_en        (ck_en),
    .soft_rst_req (soft_rst_req),
    .stage_hold   (stage_hold),
    .div_ratio    (div_ratio),
    .ch_en        (ch_en),
    .rst_out      (rst_out),
    .ce_out       (ce_out),
    .seq_done     (seq_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  int rst_exp [CH][$];
  int ce_exp  [CH][$];
  int done_exp[$];

  logic [CH-1:0] prev_rst;
  logic          prev_done;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_rst_out"},  32'(rst_out),  32'hF);
    check_val({tag, "_ce_out"},   32'(ce_out),   32'h0);
    check_val({tag, "_seq_done"}, 32'(seq_done), 32'h0);
    check_val({tag, "_busy"},     32'(busy),     32'h1);
  endtask

  task automatic check_queues_empty(input string tag);
    for (int k = 0; k < CH; k++) begin
      check_val($sformatf("%s_rst%0d_left", tag, k), 32'(rst_exp[k].size()), 32'h0);
      check_val($sformatf("%s_ce%0d_left", tag, k),  32'(ce_exp[k].size()),  32'h0);
    end
    check_val({tag, "_done_left"}, 32'(done_exp.size()), 32'h0);
  endtask

  // Advance n clock edges, sampling 1 time unit after each rising edge.
  task automatic run_cycles(input int n);
    logic nd;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      edge_n++;
      for (int k = 0; k < CH; k++) begin
        if (prev_rst[k] === 1'b1 && rst_out[k] === 1'b0) begin
          if (rst_exp[k].size() == 0)
            check_val($sformatf("rst%0d_fall_unexpected", k), 32'(edge_n), NONE);
          else
            check_val($sformatf("rst%0d_fall_edge", k), 32'(edge_n), 32'(rst_exp[k].pop_front()));
        end
        if (ce_out[k] === 1'b1) begin
          if (ce_exp[k].size() == 0)
            check_val($sformatf("ce%0d_pulse_unexpected", k), 32'(edge_n), NONE);
          else
            check_val($sformatf("ce%0d_pulse_edge", k), 32'(edge_n), 32'(ce_exp[k].pop_front()));
        end
      end
      if (prev_done === 1'b0 && seq_done === 1'b1) begin
        if (done_exp.size() == 0)
          check_val("done_rise_unexpected", 32'(edge_n), NONE);
        else
          check_val("done_rise_edge", 32'(edge_n), 32'(done_exp.pop_front()));
      end
      nd = ~seq_done;
      check_val("busy_vs_done", 32'(busy), 32'(nd));
      prev_rst  = rst_out;
      prev_done = seq_done;
    end
  endtask

  task automatic push_release(input int h);
    for (int k = 0; k < CH; k++) rst_exp[k].push_back((k + 2) * (h + 1));
    done_exp.push_back((CH + 1) * (h + 1));
  endtask

  task automatic start_numbering;
    prev_rst  = rst_out;
    prev_done = seq_done;
    edge_n    = 0;
  endtask

  initial begin
    reset        = 1'b1;
    ck_en        = 1'b1;
    soft_rst_req = 1'b0;
    stage_hold   = 16'd4;
    ch_en        = '0;
    div_ratio    = {8'd255, 8'd2, 8'd1, 8'd0};

    // Sequence timing, H=4
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    reset = 1'b0;
    start_numbering();
    push_release(4);
    run_cycles(30);
    check_queues_empty("seq_h4");

    // Zero hold
    stage_hold = 16'd0;
    reset      = 1'b1;
    run_cycles(2);
    check_reset_state("reset_in_run");
    reset = 1'b0;
    start_numbering();
    push_release(0);
    run_cycles(8);
    check_queues_empty("seq_h0");

    // Divider ratios {0,1,2,255}; channel k released on edge k+2
    ch_en = 4'b1111;
    reset = 1'b1;
    run_cycles(1);
    check_reset_state("div_reset");
    reset = 1'b0;
    start_numbering();
    push_release(0);
    for (int e = 3; e <= 300; e++)     ce_exp[0].push_back(e);
    for (int e = 5; e <= 300; e += 2)  ce_exp[1].push_back(e);
    for (int e = 7; e <= 300; e += 3)  ce_exp[2].push_back(e);
    ce_exp[3].push_back(261);
    run_cycles(300);
    check_queues_empty("div");

    // Global gating on ch2: count is 1 when ck_en drops for 5 cycles
    ch_en = 4'b0100;
    ce_exp[2].push_back(301);
    ce_exp[2].push_back(309);
    ce_exp[2].push_back(312);
    ce_exp[2].push_back(315);
    run_cycles(2);
    ck_en = 1'b0;
    run_cycles(5);
    ck_en = 1'b1;
    run_cycles(9);
    check_queues_empty("gate");

    // Soft reset in S_RUN, coincident with a ch1 pulse due on edge 322
    ch_en = 4'b0010;
    ce_exp[1].push_back(318);
    ce_exp[1].push_back(320);
    run_cycles(5);
    soft_rst_req = 1'b1;
    stage_hold   = 16'd2;
    run_cycles(1);
    check_reset_state("soft_rst");
    soft_rst_req = 1'b0;
    stage_hold   = 16'd7;
    for (int k = 0; k < CH; k++) rst_exp[k].push_back(322 + 3 * (k + 2));
    done_exp.push_back(337);
    for (int e = 333; e <= 340; e += 2) ce_exp[1].push_back(e);
    run_cycles(18);
    check_queues_empty("soft");

    // Reset mid-release, H=3
    ch_en      = 4'b0011;
    stage_hold = 16'd3;
    reset      = 1'b1;
    run_cycles(1);
    check_reset_state("mid_pre");
    reset = 1'b0;
    start_numbering();
    rst_exp[0].push_back(8);
    rst_exp[1].push_back(12);
    for (int e = 9; e <= 12; e++) ce_exp[0].push_back(e);
    run_cycles(12);
    reset = 1'b1;
    run_cycles(1);
    check_reset_state("mid_release");
    check_queues_empty("mid_first");
    reset = 1'b0;
    start_numbering();
    push_release(3);
    for (int e = 9; e <= 24; e++)      ce_exp[0].push_back(e);
    for (int e = 14; e <= 24; e += 2)  ce_exp[1].push_back(e);
    run_cycles(24);
    check_queues_empty("mid_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
